// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
//
// Configuration-chain sequencer for one programmable tile. Bitstream words
// arrive on a valid/ready stream. Each word is serialized LSB-first onto
// ccff_head, and config_enable qualifies every shift. Delivered bits are
// counted against CHAIN_LEN, and a one-cycle done pulse marks a complete load.
//
// Optional feature macro: CCFF_READBACK_EN
//   When it is defined, a CRC-8 (poly 0x07, init 0x00) is accumulated over
//   the driven bits. After the last bit, the chain is recirculated for
//   CHAIN_LEN cycles with ccff_head = ccff_tail, and a second CRC is taken
//   over the tail bits. If the two CRCs differ, err is set instead of done.
//   When it is undefined, ccff_tail is not used.
//
// Parameters
//   CHAIN_LEN  number of configuration flops in the target chain (>= 1)
//   WORD_W     bitstream word width (>= 1)
//   CNT_W      bit counter width, 2**CNT_W > CHAIN_LEN
//
// Ports
//   prog_clock     configuration clock, all state on the rising edge
//   global_reset   synchronous active-high reset
//   start          begin a chain load (honoured in idle only)
//   abort          stop the current load, return to idle, set err
//   bs_data        bitstream word, bit 0 is shifted first
//   bs_valid       bs_data valid
//   bs_ready       loader accepts a word this cycle
//   ccff_head      serial config bit to the chain head
//   ccff_tail      serial output of the chain tail
//   config_enable  chain shift enable
//   busy           loader is not idle
//   done           one-cycle pulse on successful completion
//   err            sticky error, cleared by an accepted start or by reset
//   bit_count      bits shifted in the current or last load

module ccff_chain_loader #(
    parameter int unsigned CHAIN_LEN = 5,
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              prog_clock,
    input  logic              global_reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              config_enable,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  bit_count
);

    localparam logic [CNT_W-1:0] LenC  = CNT_W'(CHAIN_LEN);
    // Largest slice a single word can contribute; min(WORD_W, CHAIN_LEN) fits CNT_W.
    localparam logic [CNT_W-1:0] WordC = (WORD_W < CHAIN_LEN) ? CNT_W'(WORD_W) : LenC;
    localparam logic [CNT_W-1:0] OneC  = CNT_W'(1);

`ifdef CCFF_READBACK_EN
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLoad   = 3'd1,
        StShift  = 3'd2,
        StVerify = 3'd3,
        StFinish = 3'd4
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLoad   = 3'd1,
        StShift  = 3'd2,
        StFinish = 3'd4
    } state_e;
`endif

    state_e             state_q, state_d;
    logic [WORD_W-1:0]  sreg_q, sreg_d;   // bits of the word still to follow ccff_head
    logic [CNT_W-1:0]   rem_q, rem_d;     // bits of the current word left, including head
    logic               head_q, head_d;
    logic               cen_q, cen_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [CNT_W-1:0]   left;
    logic [CNT_W-1:0]   take;
    logic [CNT_W-1:0]   cnt_inc;

    assign left    = LenC - cnt_q;
    assign take    = (left < WordC) ? left : WordC;
    assign cnt_inc = cnt_q + OneC;

`ifdef CCFF_READBACK_EN
    logic [7:0]        crc_tx_q, crc_tx_d;
    logic [7:0]        crc_rx_q, crc_rx_d;
    logic [CNT_W-1:0]  vcnt_q, vcnt_d;
    logic [7:0]        crc_tx_step;
    logic [7:0]        crc_rx_step;

    // Serial CRC-8, polynomial x^8 + x^2 + x + 1, MSB-side feedback.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        logic fb;
        fb = crc[7] ^ b;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    assign crc_tx_step = crc8_step(crc_tx_q, head_q);
    assign crc_rx_step = crc8_step(crc_rx_q, ccff_tail);
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        rem_d   = rem_q;
        head_d  = head_q;
        cen_d   = cen_q;
        done_d  = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;
`ifdef CCFF_READBACK_EN
        crc_tx_d = crc_tx_q;
        crc_rx_d = crc_rx_q;
        vcnt_d   = vcnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                cen_d = 1'b0;
                if (start) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                    err_d   = 1'b0;
`ifdef CCFF_READBACK_EN
                    crc_tx_d = 8'h00;
`endif
                end
            end

            StLoad: begin
                // The handshake still happens on an abort, but the word is dropped.
                if (abort) begin
                    state_d = StIdle;
                    cen_d   = 1'b0;
                    head_d  = 1'b0;
                    err_d   = 1'b1;
                end else if (bs_valid) begin
                    state_d = StShift;
                    head_d  = bs_data[0];
                    sreg_d  = bs_data >> 1;
                    rem_d   = take;
                    cen_d   = 1'b1;
                end
            end

            StShift: begin
                if (abort) begin
                    // The bit on the head this cycle is not counted.
                    state_d = StIdle;
                    cen_d   = 1'b0;
                    head_d  = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
`ifdef CCFF_READBACK_EN
                    crc_tx_d = crc_tx_step;
`endif
                    if (rem_q == OneC) begin
                        if (cnt_inc == LenC) begin
`ifdef CCFF_READBACK_EN
                            state_d  = StVerify;
                            cen_d    = 1'b1;
                            vcnt_d   = '0;
                            crc_rx_d = 8'h00;
`else
                            state_d = StFinish;
                            cen_d   = 1'b0;
                            head_d  = 1'b0;
                            done_d  = 1'b1;
`endif
                        end else begin
                            // Bubble: the head holds its last bit while the next word loads.
                            state_d = StLoad;
                            cen_d   = 1'b0;
                        end
                    end else begin
                        rem_d  = rem_q - OneC;
                        head_d = sreg_q[0];
                        sreg_d = sreg_q >> 1;
                    end
                end
            end

`ifdef CCFF_READBACK_EN
            StVerify: begin
                if (abort) begin
                    state_d = StIdle;
                    cen_d   = 1'b0;
                    head_d  = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    crc_rx_d = crc_rx_step;
                    vcnt_d   = vcnt_q + OneC;
                    // A full rotation of CHAIN_LEN shifts restores the chain contents.
                    if (vcnt_q == LenC - OneC) begin
                        cen_d  = 1'b0;
                        head_d = 1'b0;
                        if (crc_rx_step == crc_tx_q) begin
                            state_d = StFinish;
                            done_d  = 1'b1;
                        end else begin
                            state_d = StIdle;
                            err_d   = 1'b1;
                        end
                    end
                end
            end
`endif

            StFinish: begin
                state_d = StIdle;
                cen_d   = 1'b0;
                head_d  = 1'b0;
            end

            default: begin
                state_d = StIdle;
                cen_d   = 1'b0;
                head_d  = 1'b0;
            end
        endcase
    end

    // State registers
    always_ff @(posedge prog_clock) begin
        if (global_reset) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            rem_q   <= '0;
            head_q  <= 1'b0;
            cen_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef CCFF_READBACK_EN
            crc_tx_q <= 8'h00;
            crc_rx_q <= 8'h00;
            vcnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            rem_q   <= rem_d;
            head_q  <= head_d;
            cen_q   <= cen_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
`ifdef CCFF_READBACK_EN
            crc_tx_q <= crc_tx_d;
            crc_rx_q <= crc_rx_d;
            vcnt_q   <= vcnt_d;
`endif
        end
    end

    // Outputs
    assign bs_ready      = (state_q == StLoad);
    assign busy          = (state_q != StIdle);
    assign config_enable = cen_q;
    assign done          = done_q;
    assign err           = err_q;
    assign bit_count     = cnt_q;

`ifdef CCFF_READBACK_EN
    // The chain tail recirculates into the head during verification.
    assign ccff_head = (state_q == StVerify) ? ccff_tail : head_q;
`else
    assign ccff_head = head_q;
`endif

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Configuration-chain sequencer for one programmable tile (e.g. an IO tile: iopad config bits plus clock-mux select SRAM).
- Accepts bitstream words on a valid/ready stream, serializes them LSB-first onto ccff_head and qualifies each shift with config_enable.
- Counts delivered bits against the chain length, then reports done.
- Sits between the bitstream DMA/fabric config controller and the tile's ccff_head/ccff_tail pins.

Parameters:
CHAIN_LEN, 5, number of configuration flops in the target chain (>=1)
WORD_W, 8, bitstream word width (>=1)
CNT_W, 16, bit counter width; must satisfy 2^CNT_W > CHAIN_LEN

Ports:
prog_clock  input  1  configuration clock; all state on rising edge
global_reset  input  1  synchronous, active-high reset
start  input  1  pulse: begin a chain load (honoured in IDLE only)
abort  input  1  stop current load, return to IDLE, set err
bs_data  input  WORD_W  bitstream word, bit 0 shifted first
bs_valid  input  1  bs_data valid
bs_ready  output  1  loader accepts a word this cycle
ccff_head  output  1  serial config bit to chain head (registered)
ccff_tail  input  1  serial output of chain tail
config_enable  output  1  chain shift enable (registered)
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse on successful completion
err  output  1  sticky error flag, cleared only by next accepted start or reset
bit_count  output  CNT_W  bits shifted in current or last load

Behaviour:
- Reset (global_reset=1 at edge): state=IDLE; ccff_head=0, config_enable=0, bs_ready=0, busy=0, done=0, err=0, bit_count=0. Reset mid-load abandons the load; the chain keeps partial contents.
- States: IDLE, LOAD, SHIFT, (VERIFY if feature enabled), FINISH.
- IDLE: start=1 -> LOAD; clear bit_count and err. start in any other state is ignored.
- LOAD: bs_ready=1 (combinational from state), config_enable=0.
  - bs_valid&bs_ready captures the word into the shift register.
  - n = min(WORD_W, CHAIN_LEN - bit_count) is latched -> SHIFT.
- SHIFT: for n consecutive cycles, config_enable=1 and ccff_head=current word bit (bit 0 first).
  - bit_count increments on every cycle with config_enable=1.
  - The unused upper bits of a final partial word are discarded.
  - After the n-th bit: if bit_count==CHAIN_LEN -> VERIFY/FINISH, else -> LOAD.
- Latency: word accepted at edge t -> bit 0 is on ccff_head with config_enable=1 during cycle t+1.
  - Exactly one bubble cycle (config_enable=0) separates consecutive words.
  - The chain holds during bubbles and during bs_valid=0 stalls.
- FINISH: done=1 for exactly one cycle, config_enable=0, ccff_head=0 -> IDLE.
- abort=1 in LOAD/SHIFT/VERIFY: next cycle state=IDLE, config_enable=0, err=1, no done. abort in IDLE or FINISH is ignored.
- Simultaneous abort and word handshake: abort wins; the word is consumed but not shifted.
- Simultaneous global_reset and abort/start: reset wins.
- CHAIN_LEN < WORD_W: a single partial word completes the load.
- CHAIN_LEN an exact multiple of WORD_W: no partial word.
- bit_count never exceeds CHAIN_LEN; it holds its final value in IDLE.

Optional Feature:
CCFF_READBACK_EN
- Defined:
  - During SHIFT, a CRC-8 (poly 0x07, init 0x00) is accumulated over each bit driven.
  - After the last bit the loader enters VERIFY for CHAIN_LEN cycles with config_enable=1 and ccff_head=ccff_tail (combinational recirculation). The chain content is unchanged at exit.
  - A second CRC-8 is accumulated over the sampled ccff_tail bits.
  - Mismatch -> err=1 and no done pulse; match -> FINISH/done.
- Not defined: no VERIFY state, no CRC logic, and ccff_tail is unused.

Test Plan:
- CHAIN_LEN=5, WORD_W=8, start, word 0x15 -> ccff_head 1,0,1,0,1 on 5 consecutive config_enable cycles; bit_count=5; done pulse 1 cycle later; bs_ready low thereafter.
- CHAIN_LEN=20, words 0xA5,0x3C,0xFF -> 8+8+4 shift cycles with one bubble between words; upper 4 bits of 0xFF never shifted; bit_count=20; done.
- Backpressure: bs_valid deasserted 3 cycles between words -> config_enable stays 0 and ccff_head is stable; total shift cycles still exactly CHAIN_LEN.
- abort in the 3rd SHIFT cycle -> IDLE next cycle, err=1, no done, bit_count=2 held; a subsequent start clears err and a full load succeeds.
- global_reset mid-SHIFT -> all outputs return to reset values on the next edge; start is ignored while reset is held.
- CCFF_READBACK_EN with a behavioural 5-flop chain model: healthy chain -> done, err=0, chain content equals 0x15 pattern after VERIFY; chain with one stuck-at-0 flop -> err=1, no done.
